// File: rtl/serial_add_sub_digit.sv
// Digit-serial two's-complement adder/subtractor.
// Operands arrive LS digit first, DIGIT_W bits per accepted beat, and
// WORD_DIGITS beats make one word. The mode (add/sub) is taken from `sub`
// on digit 0 and held for the rest of the word. Results are registered,
// so each sum digit appears one cycle after its beat is accepted. The
// final digit of a word also reports the carry out and signed overflow.
module serial_add_sub_digit #(
  parameter  int DIGIT_W     = 1,
  parameter  int WORD_DIGITS = 16,
  localparam int CNT_W       = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

  // Word-position and carry state.
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               mode_q;

  // Combinational view of the current beat.
  logic [CNT_W-1:0]   cnt_cur;
  logic               first_digit;
  logic               last_digit;
  logic               eff_mode;
  logic               carry_in;
  logic [DIGIT_W-1:0] y_vec;
  logic [DIGIT_W-1:0] sum_d;
  logic               cout_d;
  logic               top_cin_d;

  // A synchronous clear makes this beat digit 0, whatever the counter says.
  assign cnt_cur     = clear ? '0 : cnt_q;
  assign first_digit = (cnt_cur == '0);
  assign last_digit  = (cnt_cur == LAST_IDX);

  // Digit 0 takes its mode from the port and seeds the carry with it
  // (the +1 of the two's-complement negation); later digits use the
  // latched mode and the carry from the previous digit.
  assign eff_mode = first_digit ? sub : mode_q;
  assign carry_in = first_digit ? sub : carry_q;
  assign y_vec    = b ^ {DIGIT_W{eff_mode}};

  // Ripple of DIGIT_W full adders across the digit, bitwise ops only.
  always_comb begin
    logic c;
    // NOTE: blocking assignments here build the ripple chain in order; every
    // output gets a value before the loop so no latch can be inferred.
    sum_d     = '0;
    top_cin_d = 1'b0;
    c         = carry_in;
    for (int i = 0; i < DIGIT_W; i++) begin
      top_cin_d = c;
      sum_d[i]  = a[i] ^ y_vec[i] ^ c;
      c         = (a[i] & y_vec[i]) | (c & (a[i] | y_vec[i]));
    end
    cout_d = c;
  end

  // Counter, carry and mode advance only on accepted beats; clear alone
  // restarts the word without producing output.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments and are all reset.
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
    end else if (in_valid) begin
      cnt_q   <= last_digit ? '0 : cnt_cur + CNT_W'(1);
      carry_q <= cout_d;
      mode_q  <= eff_mode;
    end else if (clear) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end
  end

  // Registered result digit and end-of-word flags; sum holds during bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_valid & last_digit;
      carry_out <= in_valid & last_digit & cout_d;
      overflow  <= in_valid & last_digit & (top_cin_d ^ cout_d);
      if (in_valid) begin
        sum <= sum_d;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub_digit.sv
// Self-checking bench for serial_add_sub_digit. One instance runs 4-bit
// digits with 4-digit words, a second runs the default 1-bit/16-digit
// configuration. Every driven cycle pushes the expected output record onto
// a per-instance queue; a monitor pops and compares it on the falling edge.
module tb_serial_add_sub_digit;

  typedef struct {
    logic       valid;
    logic [3:0] sum;
    logic       last;
    logic       cout;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-bit digit, 4-digit word instance
  logic       in_valid4, clear4, sub4;
  logic [3:0] a4, b4;
  logic       out_valid4, out_last4, carry_out4, overflow4;
  logic [3:0] sum4;

  // default 1-bit digit, 16-digit word instance
  logic in_valid1, clear1, sub1, a1, b1;
  logic out_valid1, out_last1, carry_out1, overflow1, sum1;

  serial_add_sub_digit #(.DIGIT_W(4), .WORD_DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear4), .in_valid(in_valid4),
    .a(a4), .b(b4), .sub(sub4), .out_valid(out_valid4), .sum(sum4),
    .out_last(out_last4), .carry_out(carry_out4), .overflow(overflow4)
  );

  serial_add_sub_digit dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .sum(sum1),
    .out_last(out_last1), .carry_out(carry_out1), .overflow(overflow1)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t q4[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [3:0] s, input logic last,
                              input logic c, input logic o);
    exp_t e;
    e.valid = v;
    e.sum   = s;
    e.last  = last;
    e.cout  = c;
    e.ovf   = o;
    return e;
  endfunction

  // Monitor for the 4-bit instance: one expected record per driven cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q4.size() == 0) begin
      check("dut4 idle out_valid", 32'(out_valid4), 32'd0);
    end else begin
      e = q4.pop_front();
      check("dut4 out_valid", 32'(out_valid4), 32'(e.valid));
      if (e.valid) begin
        check("dut4 sum", 32'(sum4), 32'(e.sum));
        check("dut4 out_last", 32'(out_last4), 32'(e.last));
        check("dut4 carry_out", 32'(carry_out4), 32'(e.cout));
        check("dut4 overflow", 32'(overflow4), 32'(e.ovf));
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() == 0) begin
      check("dut1 idle out_valid", 32'(out_valid1), 32'd0);
    end else begin
      e = q1.pop_front();
      check("dut1 out_valid", 32'(out_valid1), 32'(e.valid));
      if (e.valid) begin
        check("dut1 sum", 32'(sum1), 32'(e.sum[0]));
        check("dut1 out_last", 32'(out_last1), 32'(e.last));
        check("dut1 carry_out", 32'(carry_out1), 32'(e.cout));
        check("dut1 overflow", 32'(overflow1), 32'(e.ovf));
      end
    end
  end

  // Drive one cycle on the selected instance (sel=0: dut4, sel=1: dut1)
  // and queue what it must produce one cycle later.
  task automatic beat(input bit sel, input logic v, input logic [3:0] da, input logic [3:0] db,
                      input logic s, input logic clr, input exp_t e);
    @(negedge clk);
    #1;
    if (!sel) begin
      in_valid4 = v; a4 = da; b4 = db; sub4 = s; clear4 = clr;
      in_valid1 = 1'b0; clear1 = 1'b0;
      q4.push_back(e);
    end else begin
      in_valid1 = v; a1 = da[0]; b1 = db[0]; sub1 = s; clear1 = clr;
      in_valid4 = 1'b0; clear4 = 1'b0;
      q1.push_back(e);
    end
  endtask

  task automatic idle4();
    beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
  endtask

  // One 4-digit word; optional bubbles after digits 0 and 1, sub toggled on
  // digits 1..3, and clear asserted together with digit 0.
  task automatic run_word4(input vec_t v, input int gap0, input int gap1,
                           input bit toggle, input bit clr0);
    logic last;
    logic s;
    for (int d = 0; d < 4; d++) begin
      last = (d == 3);
      s    = (d != 0 && toggle) ? ~v.sub : v.sub;
      beat(1'b0, 1'b1, v.a[4*d +: 4], v.b[4*d +: 4], s, (d == 0) && clr0,
           mk(1'b1, v.s[4*d +: 4], last, last & v.c, last & v.v));
      if (d == 0) repeat (gap0) idle4();
      if (d == 1) repeat (gap1) idle4();
    end
  endtask

  // First two digits of 0x1111 + 0x1111, left unfinished.
  task automatic partial4();
    beat(1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0, mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b0));
    beat(1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0, mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b0));
  endtask

  // One 16-bit word on the 1-bit instance, bit 0 streamed first.
  task automatic run_word1(input vec_t v);
    logic last;
    for (int d = 0; d < 16; d++) begin
      last = (d == 15);
      beat(1'b1, 1'b1, {3'b000, v.a[d]}, {3'b000, v.b[d]}, v.sub, 1'b0,
           mk(1'b1, {3'b000, v.s[d]}, last, last & v.c, last & v.v));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " out_valid"}, 32'(out_valid4), 32'd0);
    check({tag, " sum"},       32'(sum4),       32'd0);
    check({tag, " out_last"},  32'(out_last4),  32'd0);
    check({tag, " carry_out"}, 32'(carry_out4), 32'd0);
    check({tag, " overflow"},  32'(overflow4),  32'd0);
    check({tag, " dut1 out_valid"}, 32'(out_valid1), 32'd0);
  endtask

  vec_t vecs[8];
  vec_t vbub;
  vec_t w1a, w1b;

  initial begin
    // {a, b, sub, expected sum, carry_out, overflow}
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vbub    = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    // Bit streams 0100_1001_1000_0001 and 0010_1010_1000_0100 in arrival order.
    w1a     = '{16'h8192, 16'h2154, 1'b0, 16'hA2E6, 1'b0, 1'b0};
    w1b     = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid4 = 1'b0; clear4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    in_valid1 = 1'b0; clear1 = 1'b0; sub1 = 1'b0; a1 = 1'b0; b1 = 1'b0;

    #2;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    // Back-to-back words at full throughput, alternating modes.
    for (int i = 0; i < 8; i++) run_word4(vecs[i], 0, 0, 1'b0, 1'b0);

    // Bubbles of 1 and 3 cycles inside a word.
    run_word4(vbub, 1, 3, 1'b0, 1'b0);
    idle4();

    // sub toggled on digits 1..3 must be ignored.
    run_word4(vecs[4], 0, 0, 1'b1, 1'b0);
    run_word4(vecs[0], 0, 0, 1'b1, 1'b0);

    // clear together with a beat: that beat is digit 0 of a new word.
    partial4();
    run_word4(vecs[0], 0, 0, 1'b0, 1'b1);

    // clear without a beat: no output, next beat is digit 0.
    partial4();
    beat(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
    run_word4(vecs[2], 0, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-word discards the partial word.
    partial4();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid4 = 1'b0;
    q4.delete();
    #1;
    check_outputs_zero("mid-word reset");
    @(negedge clk);
    #3 rst_n = 1'b1;
    run_word4(vecs[3], 0, 0, 1'b0, 1'b0);

    // Default configuration, two back-to-back 16-bit words.
    run_word1(w1a);
    run_word1(w1b);

    repeat (3) idle4();
    @(negedge clk);
    #2;
    check("dut4 queue drained", 32'(q4.size()), 32'd0);
    check("dut1 queue drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_sub_digit.md
Name: serial_add_sub_digit

Overview:
Parametrised digit-serial adder/subtractor, successor to the team's 1-bit serial adder. Operands stream in LS digit first, DIGIT_W bits per beat, with WORD_DIGITS beats per operand word. Each word runs in add or subtract mode. The block reports per-word carry-out and signed overflow on the word's last digit. It sits between serialisers in the datapath, and its arithmetic core uses only bitwise operations.

Parameters:
DIGIT_W, 1, bits processed per accepted beat (>=1)
WORD_DIGITS, 16, beats per operand word (>=2); word width = DIGIT_W*WORD_DIGITS
CNT_W, $clog2(WORD_DIGITS), digit counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  sync restart; abandons current word, next accepted beat is digit 0
in_valid  input  1  a/b/sub valid this cycle; no backpressure, beat always accepted
a  input  DIGIT_W  operand A digit, LS digit first
b  input  DIGIT_W  operand B digit, LS digit first
sub  input  1  mode; sampled only on digit 0 of a word (1 = A-B)
out_valid  output  1  registered; sum digit valid
sum  output  DIGIT_W  registered result digit
out_last  output  1  registered; marks final digit of word
carry_out  output  1  registered; carry out of word MSB, valid only when out_last=1, else 0
overflow  output  1  registered; two's-complement overflow, valid only when out_last=1, else 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0 the following are all 0: out_valid, sum, out_last, carry_out, overflow, digit counter, carry register, mode register.
- Arithmetic: each digit is a ripple of DIGIT_W full adders built only from ^ & | ~.
  - Per bit: s = x ^ y ^ c; co = (x & y) | (c & (x | y)).
  - y = b ^ {DIGIT_W{mode}}.
  - Carry-in to bit 0 = the carry register, except on digit 0, where it is the effective mode bit.
- Mode: on digit 0, effective mode = the sub input, latched into the mode register. On later digits, the mode register is used and the sub input is ignored.
- Digit counter and carry register: update only on beats where in_valid=1.
  - The counter counts 0..WORD_DIGITS-1, then wraps to 0.
  - The carry register takes the digit's carry-out on every accepted beat.
- Gaps: in_valid=0 bubbles may occur anywhere inside a word. During a bubble, counter, carry and mode hold, and out_valid=0 on the following cycle.
- Latency: exactly 1 cycle.
  - A beat accepted at edge k drives out_valid=1 with its sum during cycle k+1.
  - With no beat, out_valid=0; sum holds its last value (don't-care).
- Last digit (counter = WORD_DIGITS-1):
  - out_last=1.
  - carry_out = carry out of the top bit.
  - overflow = carry into top bit ^ carry out of top bit.
  - For subtract, carry_out=1 means no borrow.
- Wrap: the beat after a last digit is digit 0 of a new word. Carry is re-seeded from the new word's sub, so there is no carry leak between words.
- clear=1 at an edge resets the counter to 0 and the carry to 0.
  - If in_valid=1 in the same cycle, that beat is processed as digit 0 of a new word, using sub, and produces its output normally.
  - clear with in_valid=0 produces no output.
- rst_n asserted mid-word: the partial word is discarded with no output. After release, the next beat is digit 0.
- Continuous in_valid gives full throughput: one digit per cycle, back-to-back words.

Test Plan:
- DIGIT_W=4, WORD_DIGITS=4; add A=0x1234, B=0x0FFF, digits 4,3,2,1 / F,F,F,0 -> sum digits 3,3,2,2 (0x2233); last beat: out_last=1, carry_out=0, overflow=0.
- Same config; sub A=0x0001, B=0x0002 -> 0xFFFF (digits F,F,F,F); carry_out=0 (borrow), overflow=0. Next back-to-back word: add 0x7FFF+0x0001 -> 0x8000, overflow=1, carry_out=0. This checks that carry is re-seeded at the word boundary.
- Add 0xFFFF+0x0001 with in_valid bubbles of 1 and 3 cycles between digits -> 0x0000, carry_out=1, overflow=0; out_valid=0 exactly in the cycles after bubbles.
- Default params (DIGIT_W=1, WORD_DIGITS=16); bit streams a=0100_1001_1000_0001, b=0010_1010_1000_0100, mode add -> sum 0110_0111_0100_0101; out_last on the 16th output only.
- Mid-word events:
  - clear after digit 2 of a 4-digit word, with in_valid=1 in the same cycle -> that beat is treated as digit 0, new result correct.
  - rst_n pulsed low mid-word -> outputs go 0 asynchronously; next word is computed correctly from digit 0.
- Toggle sub on non-zero digits within a word -> result unaffected; matches the mode sampled on digit 0.
